// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and the round-robin picker it uses.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int STAT_W = 16;

    // One-hot of idx within an n-bit field; callers truncate to their own width.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
        logic [31:0] v;
        v = '0;
        if (idx < n && idx < 32) begin
            v = 32'd1 << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ burst producers.
// Optional per-requester beat counters are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int BURST_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    input  logic                  fifo_full,
    output logic                  fifo_w_en,
    output logic [WIDTH-1:0]      fifo_data_in
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [NREQ*STAT_W-1:0] beat_total
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic            owner_req;
    logic            beat;
    logic            last_beat;
    logic            release_grant;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req     = req[owner_q];
    assign beat          = (state_q == GRANT) && owner_req && !fifo_full;
    assign last_beat     = beat && (req_last[owner_q] || (beat_cnt_q == CW'(BURST_MAX - 1)));
    // A dropped request abandons the burst even during a stall; fullness alone never releases.
    assign release_grant = (state_q == GRANT) && (!owner_req || last_beat);

    always_comb begin
        ack = '0;
        if (beat) begin
            ack[owner_q] = 1'b1;
        end
    end

    assign fifo_w_en    = beat;
    assign fifo_data_in = (state_q == GRANT) ? req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;
    assign gnt          = gnt_q;
    assign busy         = busy_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    gnt_d      = NREQ'(onehot(int'(pick_idx), NREQ));
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Saturating accepted-beat counters; a clear beats a same-cycle increment.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
        logic [STAT_W-1:0] stat_q, stat_d;

        always_comb begin
            stat_d = stat_q;
            if (stats_clr) begin
                stat_d = '0;
            end else if (ack[gi] && (stat_q != '1)) begin
                stat_d = stat_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_q <= '0;
            end else begin
                stat_q <= stat_d;
            end
        end

        assign beat_total[gi*STAT_W +: STAT_W] = stat_q;
    end
`endif

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
Round-robin write arbiter that lets NREQ producers share the write port of one sync_fifo instance. It grants one requester at a time, locks the grant for a burst, and gates writes on the FIFO full flag. The FIFO is instantiated by the parent; this block drives its w_en and data_in and observes its full.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 16, data width; must match the FIFO WIDTH
BURST_MAX, 8, maximum beats per grant before forced release (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  NREQ  per-requester write request (valid)
req_data  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
req_last  input  NREQ  marks the final beat of requester i's burst
ack  output  NREQ  beat accepted this cycle (combinational)
gnt  output  NREQ  registered one-hot grant, or all-zero
busy  output  1  registered; high while a grant is held
fifo_full  input  1  full flag from the FIFO
fifo_w_en  output  1  FIFO write enable (combinational)
fifo_data_in  output  WIDTH  FIFO write data (combinational mux)

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rst). In reset: state=IDLE, gnt=0, busy=0, rr_ptr=0, beat_cnt=0. While gnt=0, ack=0 and fifo_w_en=0.
- State machine:
  - IDLE: if any req is high, pick owner = the first requester with req high, searching from rr_ptr upward with wrap.
  - IDLE transition on the next edge: gnt=onehot(owner), busy=1, beat_cnt=0, state=GRANT.
  - IDLE with no req: hold.
- GRANT beats:
  - ack[owner] = req[owner] & ~fifo_full; fifo_w_en = |ack; fifo_data_in = req_data[owner] while granted, else 0.
  - Each ack is one beat; beat_cnt increments.
- GRANT release (evaluated at the clock edge). Release occurs on any of:
  - a beat with req_last[owner]=1;
  - a beat with beat_cnt==BURST_MAX-1;
  - req[owner]=0 for one cycle (abandon).
- On release: state=IDLE, gnt=0, busy=0, rr_ptr=(owner+1) mod NREQ.
- Latency: req rising in IDLE at cycle t gives gnt at t+1; the first ack is at t+1 if not full. One dead cycle (IDLE) always separates consecutive grants.
- Handshake: requesters hold req, req_data and req_last stable until ack. A non-owner never receives ack.
- fifo_full high: no beat, beat_cnt holds, grant held. A stall never causes release.
- Requests from other requesters during GRANT are ignored until IDLE. No preemption.
- Counter width: beat_cnt is $clog2(BURST_MAX+1) bits; rr_ptr is $clog2(NREQ) bits; rr_ptr wraps NREQ-1 -> 0.
- Reset mid-burst: the grant is dropped immediately (async). A partially written burst stays in the FIFO; clearing it is the parent's job.

Optional Feature:
FIFO_WR_ARB_STATS_EN
- Defined:
  - Adds output beat_total of NREQ*16 bits: per-requester 16-bit counters of accepted beats, saturating at 16'hFFFF.
  - Adds input stats_clr (1 bit): synchronous clear; it wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: these ports and the logic behind them do not exist.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_e;
  - localparam STAT_W=16;
  - function onehot(idx, n).
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: found, idx.
  - Reused by later read-side schedulers.

Test Plan:
1. Round-robin: req=4'b1111, each req_last=1 on the first beat → grants in order 0,1,2,3,0. Each grant is one beat, one IDLE cycle between grants, fifo_w_en pattern 1,0,1,0.
2. Burst cap: BURST_MAX=8, req[2] held high, req_last=0 → exactly 8 acks to requester 2, then release; next grant goes to the next requester after 2 that has req high.
3. Full stall: mid-burst for requester 1, fifo_full=1 for 5 cycles → ack=0, fifo_w_en=0, gnt stays 4'b0010, beat_cnt frozen. On fifo_full=0 the burst resumes with the same data word.
4. Abandon: owner 0 drops req after 2 beats, no last → next edge gnt=0, rr_ptr=1. A waiting req[3] is granted 2 cycles after the drop.
5. Async reset: assert rst mid-grant between clock edges → gnt=0, busy=0, fifo_w_en=0 immediately. After release, req=4'b1000 is granted to requester 3 (rr_ptr=0 search).
6. FIFO_WR_ARB_STATS_EN: 10 beats from requester 1 → beat_total[1]=10. stats_clr coinciding with a beat → 0. Forced 0xFFFF plus one beat → stays 0xFFFF.
